// File: rtl/dip_frame_filter.sv
// Frame detector, debouncer and valid/ack presenter for the parallel DIP reader word.
// Also flags overrun of an unacknowledged value and loss of frames (stale).
module dip_frame_filter #(
  parameter int WIDTH          = 16,
  parameter int STABLE_FRAMES  = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] DIP_data,
  input  logic             DIP_latch,
  input  logic             change_ack,
  output logic [WIDTH-1:0] dip_value,
  output logic             change_valid,
  output logic             overrun,
  output logic             stale,
  output logic             frame_strobe
);

  localparam int              TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]      STABLE = 4'(STABLE_FRAMES);
  localparam logic [TW-1:0]   TMAX   = TW'(TIMEOUT_CYCLES);

  logic             latch_q;
  logic             frame_strobe_q, frame_strobe_d;
  logic [WIDTH-1:0] candidate_q, candidate_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [WIDTH-1:0] dip_value_q, dip_value_d;
  logic             change_valid_q, change_valid_d;
  logic             overrun_q, overrun_d;
  logic [TW-1:0]    timeout_cnt_q, timeout_cnt_d;
  logic             stale_q, stale_d;
  logic             fe;
  logic             accept;

  // Frame edge detection, debounce, handshake and watchdog next-state
  always_comb begin
    fe             = latch_q & ~DIP_latch;
    accept         = 1'b0;
    frame_strobe_d = fe;
    candidate_d    = candidate_q;
    match_cnt_d    = match_cnt_q;
    dip_value_d    = dip_value_q;
    change_valid_d = change_valid_q;
    overrun_d      = overrun_q;
    timeout_cnt_d  = timeout_cnt_q;

    if (fe) begin
      if ((DIP_data == candidate_q) && (match_cnt_q != 4'd0)) begin
        match_cnt_d = (match_cnt_q >= STABLE) ? STABLE : match_cnt_q + 4'd1;
      end else begin
        candidate_d = DIP_data;
        match_cnt_d = 4'd1;
      end
      accept = (match_cnt_d == STABLE) && (DIP_data != dip_value_q);
    end else begin
      accept = 1'b0;
    end

    // A coincident ack never clears a freshly accepted value, nor touches overrun.
    if (accept) begin
      dip_value_d    = DIP_data;
      change_valid_d = 1'b1;
      if (change_valid_q && !change_ack) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end else if (change_ack && change_valid_q) begin
      change_valid_d = 1'b0;
      overrun_d      = 1'b0;
    end else begin
      change_valid_d = change_valid_q;
    end

    if (fe) begin
      timeout_cnt_d = {TW{1'b0}};
    end else if (timeout_cnt_q != TMAX) begin
      timeout_cnt_d = timeout_cnt_q + TW'(1);
    end else begin
      timeout_cnt_d = timeout_cnt_q;
    end
    stale_d = (timeout_cnt_d == TMAX);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_q        <= 1'b0;
      frame_strobe_q <= 1'b0;
      candidate_q    <= {WIDTH{1'b0}};
      match_cnt_q    <= 4'd0;
      dip_value_q    <= {WIDTH{1'b0}};
      change_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_cnt_q  <= {TW{1'b0}};
      stale_q        <= 1'b0;
    end else begin
      latch_q        <= DIP_latch;
      frame_strobe_q <= frame_strobe_d;
      candidate_q    <= candidate_d;
      match_cnt_q    <= match_cnt_d;
      dip_value_q    <= dip_value_d;
      change_valid_q <= change_valid_d;
      overrun_q      <= overrun_d;
      timeout_cnt_q  <= timeout_cnt_d;
      stale_q        <= stale_d;
    end
  end

  assign dip_value    = dip_value_q;
  assign change_valid = change_valid_q;
  assign overrun      = overrun_q;
  assign stale        = stale_q;
  assign frame_strobe = frame_strobe_q;

endmodule

// File: tb/tb_dip_frame_filter.sv
// Directed plus randomized bench for dip_frame_filter against a run-length reference model.
module tb_dip_frame_filter;

  localparam int S = 3;
  localparam int T = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] DIP_data;
  logic        DIP_latch;
  logic        change_ack;
  logic [15:0] dip_value;
  logic        change_valid, overrun, stale, frame_strobe;

  dip_frame_filter #(.WIDTH(16), .STABLE_FRAMES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .DIP_data(DIP_data), .DIP_latch(DIP_latch),
    .change_ack(change_ack), .dip_value(dip_value), .change_valid(change_valid),
    .overrun(overrun), .stale(stale), .frame_strobe(frame_strobe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int strobes = 0;
  bit rand_ack = 1'b0;

  // reference model: run length of identical frames, last accepted value, idle cycles
  logic [15:0] m_value, m_last;
  int          m_run, m_idle;
  bit          m_valid, m_ovr, m_strobe, m_latch;

  function automatic void m_reset();
    m_value = 16'd0; m_last = 16'd0; m_run = 0; m_idle = 0;
    m_valid = 1'b0; m_ovr = 1'b0; m_strobe = 1'b0; m_latch = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dip_value", dip_value, m_value);
    chk("change_valid", {15'd0, change_valid}, {15'd0, m_valid});
    chk("overrun", {15'd0, overrun}, {15'd0, m_ovr});
    chk("stale", {15'd0, stale}, {15'd0, (m_idle == T)});
    chk("frame_strobe", {15'd0, frame_strobe}, {15'd0, m_strobe});
  endtask

  task automatic tick();
    bit fe, acc;
    if (rand_ack) change_ack = ($urandom_range(0, 3) == 0);
    if (rst) begin
      m_reset();
    end else begin
      fe = m_latch && !DIP_latch;
      acc = 1'b0;
      m_strobe = fe;
      if (fe) begin
        m_run  = (m_run > 0 && DIP_data == m_last) ? m_run + 1 : 1;
        m_last = DIP_data;
        m_idle = 0;
        acc = (m_run >= S) && (DIP_data != m_value);
      end else if (m_idle < T) begin
        m_idle++;
      end
      if (acc) begin
        if (m_valid && !change_ack) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_value = DIP_data;
      end else if (change_ack && m_valid) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      m_latch = DIP_latch;
    end
    @(posedge clk);
    #1;
    if (frame_strobe) strobes++;
    check_all();
  endtask

  task automatic frame(input logic [15:0] d, input int hi, input int lo, input bit ack_fe);
    DIP_latch = 1'b1;
    repeat (hi) begin
      DIP_data = 16'($urandom);
      tick();
    end
    DIP_data  = d;
    DIP_latch = 1'b0;
    if (ack_fe) change_ack = 1'b1;
    repeat (lo) tick();
    if (ack_fe) change_ack = 1'b0;
    DIP_latch = 1'b1;
  endtask

  task automatic f17(input logic [15:0] d);
    frame(d, 16, 1, 1'b0);
  endtask

  task automatic ack_pulse();
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
  endtask

  logic [15:0] pool [3];

  initial begin
    rst = 1'b1; DIP_data = 16'd0; DIP_latch = 1'b0; change_ack = 1'b0;
    m_reset();
    #1;
    check_all();
    repeat (2) tick();
    rst = 1'b0;

    // three identical frames, 17-cycle period
    strobes = 0;
    f17(16'hA5C3); f17(16'hA5C3);
    chk("t1_not_yet", {15'd0, change_valid}, 16'd0);
    f17(16'hA5C3);
    chk("t1_value", dip_value, 16'hA5C3);
    chk("t1_valid", {15'd0, change_valid}, 16'd1);
    tick();
    chk("t1_strobes", 16'(strobes), 16'd3);
    ack_pulse();

    // glitch frame restarts the count
    f17(16'h00FF); f17(16'h00FF); f17(16'h0F0F); f17(16'h00FF); f17(16'h00FF);
    chk("t2_hold", dip_value, 16'hA5C3);
    f17(16'h00FF);
    chk("t2_value", dip_value, 16'h00FF);
    ack_pulse();

    // overrun
    repeat (3) f17(16'h1234);
    chk("t3_first", dip_value, 16'h1234);
    repeat (3) f17(16'h5678);
    chk("t3_value", dip_value, 16'h5678);
    chk("t3_valid", {15'd0, change_valid}, 16'd1);
    chk("t3_ovr", {15'd0, overrun}, 16'd1);
    ack_pulse();
    chk("t3_valid_clr", {15'd0, change_valid}, 16'd0);
    chk("t3_ovr_clr", {15'd0, overrun}, 16'd0);

    // ack coincident with accept
    f17(16'hBEEF); f17(16'hBEEF);
    frame(16'hBEEF, 16, 1, 1'b1);
    chk("t4_valid", {15'd0, change_valid}, 16'd1);
    chk("t4_ovr", {15'd0, overrun}, 16'd0);
    chk("t4_value", dip_value, 16'hBEEF);
    ack_pulse();
    chk("t4_valid_clr", {15'd0, change_valid}, 16'd0);

    // stale watchdog (one ack_pulse tick already elapsed since last FE)
    DIP_latch = 1'b1;
    repeat (1022) tick();
    chk("t5_not_stale", {15'd0, stale}, 16'd0);
    tick();
    chk("t5_stale", {15'd0, stale}, 16'd1);
    repeat (1100 - 1024) tick();
    chk("t5_still_stale", {15'd0, stale}, 16'd1);
    DIP_data = 16'h4321; DIP_latch = 1'b0;
    tick();
    DIP_latch = 1'b1;
    chk("t5_stale_clr", {15'd0, stale}, 16'd0);
    chk("t5_value", dip_value, 16'hBEEF);

    // reset mid-debounce
    f17(16'h7777); f17(16'h7777);
    DIP_data = 16'h7777; DIP_latch = 1'b0;
    rst = 1'b1;
    #1;
    m_reset();
    check_all();
    repeat (2) tick();
    chk("t6_rst_value", dip_value, 16'd0);
    rst = 1'b0;
    tick();
    chk("t6_no_fe", {15'd0, frame_strobe}, 16'd0);
    f17(16'h7777); f17(16'h7777);
    chk("t6_two", dip_value, 16'd0);
    f17(16'h7777);
    chk("t6_value", dip_value, 16'h7777);
    chk("t6_valid", {15'd0, change_valid}, 16'd1);

    // randomized frames, periods, low lengths, acks and occasional resets
    for (int k = 0; k < 3; k++) pool[k] = 16'($urandom);
    rand_ack = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 60) == 0) begin
        rst = 1'b1;
        #1;
        m_reset();
        check_all();
        tick();
        rst = 1'b0;
      end
      frame(pool[$urandom_range(0, 2)], $urandom_range(1, 5), $urandom_range(1, 3), 1'b0);
    end
    rand_ack = 1'b0;
    change_ack = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
